multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Main control FSM plus instruction/ALU decode for the RV32 multicycle core. Sits upstream of the
//  register file and drives its write enable (reg_write -> WE3) and all datapath mux selects.
//  Sequences fetch/decode/execute/memory/writeback per instruction; counts retired instructions.
// PARAMETERS
//  CNT_W      32   width of retired-instruction counter instret (wraps modulo 2^CNT_W)
// PORTS
//  clk          in   1      core clock; all state changes on posedge
//  rst          in   1      synchronous, active-high reset
//  op           in   7      instr[6:0] from instruction register
//  funct3       in   3      instr[14:12]
//  funct7b5     in   1      instr[30]
//  zero         in   1      ALU zero flag (current cycle)
//  pc_write     out  1      PC register enable
//  adr_src      out  1      0=PC, 1=ALUOut to memory address
//  mem_write    out  1      data memory write enable
//  ir_write     out  1      instruction register enable
//  reg_write    out  1      register file write enable
//  result_src   out  2      00=ALUOut, 01=ReadData, 10=ALUResult
//  alu_src_a    out  2      00=PC, 01=OldPC, 10=A reg
//  alu_src_b    out  2      00=B reg, 01=ImmExt, 10=const 4
//  imm_src      out  2      00=I, 01=S, 10=B, 11=J
//  alu_control  out  3      000 add, 001 sub, 010 and, 011 or, 101 slt
//  illegal_op   out  1      1-cycle pulse in DECODE on unsupported opcode
//  instr_done   out  1      high in last cycle of each instruction
//  instret      out  CNT_W  retired-instruction count
// BEHAVIOUR
//  - rst high: state<=FETCH, instret<=0 next edge; while rst high pc_write, ir_write, reg_write,
//    mem_write, illegal_op, instr_done forced 0; mux selects hold FETCH values. Reset mid-instruction
//    aborts it; no partial write escapes.
//  - Moore outputs from state (unlisted = 0/00); pc_write = pc_update | (branch & zero).
//  - FETCH: adr_src0 ir_write src_a00 src_b10 aluop00 result10 pc_update -> DECODE
//  - DECODE: src_a01 src_b01 aluop00 -> lw/sw(0000011/0100011) MEMADR, R(0110011) EXECR,
//    I(0010011) EXECI, jal(1101111) JAL, beq(1100011) BEQ, else illegal_op=1 and -> FETCH
//  - MEMADR: src_a10 src_b01 aluop00 -> MEMREAD if op[5]=0 else MEMWRITE
//  - MEMREAD: result00 adr_src1 -> MEMWB;  MEMWB: result01 reg_write, done -> FETCH
//  - MEMWRITE: result00 adr_src1 mem_write, done -> FETCH
//  - EXECR: src_a10 src_b00 aluop10 -> ALUWB;  EXECI: src_a10 src_b01 aluop10 -> ALUWB
//  - ALUWB: result00 reg_write, done -> FETCH
//  - JAL: src_a01 src_b10 aluop00 result00 pc_update -> ALUWB
//  - BEQ: src_a10 src_b00 aluop01 result00 branch, done -> FETCH
//  - Latency (cycles incl. FETCH): lw 5, sw 4, R/I 4, jal 4, beq 3, illegal 2 (not counted).
//  - instr_done high in MEMWB, MEMWRITE, ALUWB, BEQ; instret increments that edge, wraps to 0.
//  - imm_src from op alone: sw 01, beq 10, jal 11, all others 00.
//  - ALU decode: aluop00 add; 01 sub; 10 by funct3: 000 -> sub if op[5]&funct7b5 else add,
//    010 slt, 110 or, 111 and, others add.
//  - Illegal states (encodings 11-15) -> FETCH next cycle, outputs as FETCH with enables 0.
// STRUCTURE
//  - Shared package: opcode constants, state encodings (4-bit, FETCH=0), alu_control codes,
//    result/src mux select codes.
//  - One sub-module: alu_decoder (aluop, funct3, op5, funct7b5 -> alu_control), combinational.
//  - Top: state register, next-state case, output decode, instret counter.
// TESTING
//  - rst 2 cycles, release, IR=lw: states 0,1,2,3,4,0; reg_write only in MEMWB; instret 0->1.
//  - sw x: mem_write=1 exactly 1 cycle in MEMWRITE with adr_src=1; reg_write never high.
//  - beq zero=1 -> pc_write=1 in BEQ; zero=0 -> pc_write=0; both bump instret, 3 cycles.
//  - R sub (funct3=000, funct7b5=1) -> alu_control=001 in EXECR; addi funct7b5=1 -> 000.
//  - op=0000000 -> illegal_op pulse in DECODE, back to FETCH, instret unchanged.
//  - rst asserted in MEMWB -> reg_write=0 that cycle, FETCH next; CNT_W=4 at 15 +1 -> 0.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared constants for the RV32 multicycle control path: opcodes, FSM state
// encodings, mux select codes, ALU codes and the control-word bundle.
package multicycle_control_pkg;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_JAL      = 4'd9;
    localparam logic [3:0] S_BEQ      = 4'd10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_READDATA  = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    typedef struct packed {
        logic       pc_update;
        logic       branch;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       done;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    // FETCH mux selects with every enable low; used in reset and for bad states.
    localparam ctrl_t CTRL_IDLE = '{
        pc_update: 1'b0, branch: 1'b0, adr_src: 1'b0, mem_write: 1'b0,
        ir_write: 1'b0, reg_write: 1'b0, done: 1'b0,
        result_src: RES_ALURESULT, alu_src_a: SRCA_PC,
        alu_src_b: SRCB_FOUR, alu_op: ALUOP_ADD};

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// Combinational ALU decoder: maps the FSM's aluop plus instruction fields to
// the ALU operation code.
module alu_decoder
    import multicycle_control_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);

    // Only R-type sets op5, so addi with instr[30] set still adds.
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNC: begin
                case (funct3)
                    3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the RV32 multicycle core: sequences each instruction,
// drives datapath enables and mux selects, and counts retired instructions.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             zero,
    output logic             pc_write,
    output logic             adr_src,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       imm_src,
    output logic [2:0]       alu_control,
    output logic             illegal_op,
    output logic             instr_done,
    output logic [CNT_W-1:0] instret
);

    logic [3:0] state;
    logic [3:0] next_state;
    logic       op_legal;
    ctrl_t      ctrl;
    ctrl_t      ctrl_eff;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_FETCH;
            instret <= '0;
        end else begin
            state <= next_state;
            if (ctrl.done)
                instret <= instret + CNT_W'(1);
        end
    end

    always_comb begin
        op_legal = (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
                   (op == OP_ITYPE) || (op == OP_JAL) || (op == OP_BEQ);
    end

    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH:  next_state = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_EXECR;
                    OP_ITYPE:     next_state = S_EXECI;
                    OP_JAL:       next_state = S_JAL;
                    OP_BEQ:       next_state = S_BEQ;
                    default:      next_state = S_FETCH;
                endcase
            end
            S_MEMADR:   next_state = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  next_state = S_MEMWB;
            S_EXECR:    next_state = S_ALUWB;
            S_EXECI:    next_state = S_ALUWB;
            S_JAL:      next_state = S_ALUWB;
            default:    next_state = S_FETCH;
        endcase
    end

    // Moore control word; states not listed fall back to idle FETCH selects.
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl           = CTRL_IDLE;
                ctrl.ir_write  = 1'b1;
                ctrl.pc_update = 1'b1;
            end
            S_DECODE: begin
                ctrl.alu_src_a = SRCA_OLDPC;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = SRCA_A;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                ctrl.adr_src = 1'b1;
            end
            S_MEMWB: begin
                ctrl.result_src = RES_READDATA;
                ctrl.reg_write  = 1'b1;
                ctrl.done       = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl.adr_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.done      = 1'b1;
            end
            S_EXECR: begin
                ctrl.alu_src_a = SRCA_A;
                ctrl.alu_op    = ALUOP_FUNC;
            end
            S_EXECI: begin
                ctrl.alu_src_a = SRCA_A;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_FUNC;
            end
            S_ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.done      = 1'b1;
            end
            S_JAL: begin
                ctrl.alu_src_a = SRCA_OLDPC;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.pc_update = 1'b1;
            end
            S_BEQ: begin
                ctrl.alu_src_a = SRCA_A;
                ctrl.alu_op    = ALUOP_SUB;
                ctrl.branch    = 1'b1;
                ctrl.done      = 1'b1;
            end
            default: ctrl = CTRL_IDLE;
        endcase
    end

    // Reset overrides the state decode so an aborted instruction cannot write.
    always_comb begin
        ctrl_eff = rst ? CTRL_IDLE : ctrl;
    end

    always_comb begin
        pc_write   = ctrl_eff.pc_update | (ctrl_eff.branch & zero);
        adr_src    = ctrl_eff.adr_src;
        mem_write  = ctrl_eff.mem_write;
        ir_write   = ctrl_eff.ir_write;
        reg_write  = ctrl_eff.reg_write;
        result_src = ctrl_eff.result_src;
        alu_src_a  = ctrl_eff.alu_src_a;
        alu_src_b  = ctrl_eff.alu_src_b;
        instr_done = ctrl_eff.done;
        illegal_op = !rst && (state == S_DECODE) && !op_legal;
    end

    always_comb begin
        case (op)
            OP_SW:   imm_src = IMM_S;
            OP_BEQ:  imm_src = IMM_B;
            OP_JAL:  imm_src = IMM_J;
            default: imm_src = IMM_I;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op      (ctrl_eff.alu_op),
        .funct3      (funct3),
        .op5         (op[5]),
        .funct7b5    (funct7b5),
        .alu_control (alu_control)
    );

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class through
// the FSM and compares the packed control signature every cycle.
module tb_multicycle_control;

    localparam int CNT_W = 4;

    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] SW   = 7'b0100011;
    localparam logic [6:0] RTY  = 7'b0110011;
    localparam logic [6:0] ITY  = 7'b0010011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] BEQ  = 7'b1100011;
    localparam logic [6:0] BAD  = 7'b0000000;

    // Signature: pcw adr mw irw rw res[2] srca[2] srcb[2] ill done
    localparam logic [12:0] SIG_RST      = 13'b0_0_0_0_0_10_00_10_0_0;
    localparam logic [12:0] SIG_FETCH    = 13'b1_0_0_1_0_10_00_10_0_0;
    localparam logic [12:0] SIG_DECODE   = 13'b0_0_0_0_0_00_01_01_0_0;
    localparam logic [12:0] SIG_DEC_ILL  = 13'b0_0_0_0_0_00_01_01_1_0;
    localparam logic [12:0] SIG_MEMADR   = 13'b0_0_0_0_0_00_10_01_0_0;
    localparam logic [12:0] SIG_MEMREAD  = 13'b0_1_0_0_0_00_00_00_0_0;
    localparam logic [12:0] SIG_MEMWB    = 13'b0_0_0_0_1_01_00_00_0_1;
    localparam logic [12:0] SIG_MEMWRITE = 13'b0_1_1_0_0_00_00_00_0_1;
    localparam logic [12:0] SIG_EXECR    = 13'b0_0_0_0_0_00_10_00_0_0;
    localparam logic [12:0] SIG_EXECI    = 13'b0_0_0_0_0_00_10_01_0_0;
    localparam logic [12:0] SIG_ALUWB    = 13'b0_0_0_0_1_00_00_00_0_1;
    localparam logic [12:0] SIG_JAL      = 13'b1_0_0_0_0_00_01_10_0_0;
    localparam logic [12:0] SIG_BEQ_T    = 13'b1_0_0_0_0_00_10_00_0_1;
    localparam logic [12:0] SIG_BEQ_NT   = 13'b0_0_0_0_0_00_10_00_0_1;

    logic             clk;
    logic             rst;
    logic [6:0]       op;
    logic [2:0]       funct3;
    logic             funct7b5;
    logic             zero;
    logic             pc_write;
    logic             adr_src;
    logic             mem_write;
    logic             ir_write;
    logic             reg_write;
    logic [1:0]       result_src;
    logic [1:0]       alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       imm_src;
    logic [2:0]       alu_control;
    logic             illegal_op;
    logic             instr_done;
    logic [CNT_W-1:0] instret;
    logic [12:0]      sig;

    int vectors = 0;
    int miscompares = 0;

    multicycle_control #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .op          (op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .zero        (zero),
        .pc_write    (pc_write),
        .adr_src     (adr_src),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .reg_write   (reg_write),
        .result_src  (result_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .imm_src     (imm_src),
        .alu_control (alu_control),
        .illegal_op  (illegal_op),
        .instr_done  (instr_done),
        .instret     (instret)
    );

    assign sig = {pc_write, adr_src, mem_write, ir_write, reg_write,
                  result_src, alu_src_a, alu_src_b, illegal_op, instr_done};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic r, input logic [6:0] o,
                                 input logic [2:0] f3, input logic f7,
                                 input logic z);
        rst      = r;
        op       = o;
        funct3   = f3;
        funct7b5 = f7;
        zero     = z;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        applyStimulus(1'b1, LW, 3'b010, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("reset_sig", 32'(sig), 32'(SIG_RST));
        checkOutput("reset_instret", 32'(instret), 32'd0);

        // lw: FETCH DECODE MEMADR MEMREAD MEMWB
        applyStimulus(1'b0, LW, 3'b010, 1'b0, 1'b0);
        checkOutput("lw_fetch", 32'(sig), 32'(SIG_FETCH));
        checkOutput("lw_imm", 32'(imm_src), 32'd0);
        tick();
        checkOutput("lw_decode", 32'(sig), 32'(SIG_DECODE));
        tick();
        checkOutput("lw_memadr", 32'(sig), 32'(SIG_MEMADR));
        checkOutput("lw_memadr_alu", 32'(alu_control), 32'b000);
        tick();
        checkOutput("lw_memread", 32'(sig), 32'(SIG_MEMREAD));
        tick();
        checkOutput("lw_memwb", 32'(sig), 32'(SIG_MEMWB));
        checkOutput("lw_memwb_instret", 32'(instret), 32'd0);
        tick();
        checkOutput("lw_back_fetch", 32'(sig), 32'(SIG_FETCH));
        checkOutput("lw_instret", 32'(instret), 32'd1);

        // sw: FETCH DECODE MEMADR MEMWRITE
        applyStimulus(1'b0, SW, 3'b010, 1'b0, 1'b0);
        checkOutput("sw_imm", 32'(imm_src), 32'b01);
        tick();
        checkOutput("sw_decode", 32'(sig), 32'(SIG_DECODE));
        tick();
        checkOutput("sw_memadr", 32'(sig), 32'(SIG_MEMADR));
        tick();
        checkOutput("sw_memwrite", 32'(sig), 32'(SIG_MEMWRITE));
        tick();
        checkOutput("sw_back_fetch", 32'(sig), 32'(SIG_FETCH));
        checkOutput("sw_instret", 32'(instret), 32'd2);

        // beq taken
        applyStimulus(1'b0, BEQ, 3'b000, 1'b0, 1'b1);
        tick();
        checkOutput("beq_t_imm", 32'(imm_src), 32'b10);
        tick();
        checkOutput("beq_t_state", 32'(sig), 32'(SIG_BEQ_T));
        checkOutput("beq_t_alu", 32'(alu_control), 32'b001);
        tick();
        checkOutput("beq_t_instret", 32'(instret), 32'd3);

        // beq not taken
        applyStimulus(1'b0, BEQ, 3'b000, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("beq_nt_state", 32'(sig), 32'(SIG_BEQ_NT));
        tick();
        checkOutput("beq_nt_fetch", 32'(sig), 32'(SIG_FETCH));
        checkOutput("beq_nt_instret", 32'(instret), 32'd4);

        // R-type sub
        applyStimulus(1'b0, RTY, 3'b000, 1'b1, 1'b0);
        tick();
        tick();
        checkOutput("sub_execr", 32'(sig), 32'(SIG_EXECR));
        checkOutput("sub_alu", 32'(alu_control), 32'b001);
        tick();
        checkOutput("sub_aluwb", 32'(sig), 32'(SIG_ALUWB));
        tick();
        checkOutput("sub_instret", 32'(instret), 32'd5);

        // addi with instr[30] set still adds
        applyStimulus(1'b0, ITY, 3'b000, 1'b1, 1'b0);
        tick();
        tick();
        checkOutput("addi_execi", 32'(sig), 32'(SIG_EXECI));
        checkOutput("addi_alu", 32'(alu_control), 32'b000);
        tick();
        checkOutput("addi_aluwb", 32'(sig), 32'(SIG_ALUWB));
        tick();
        checkOutput("addi_instret", 32'(instret), 32'd6);

        // R-type and, I-type slt, I-type or
        applyStimulus(1'b0, RTY, 3'b111, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("and_alu", 32'(alu_control), 32'b010);
        tick();
        tick();
        applyStimulus(1'b0, ITY, 3'b010, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("slti_alu", 32'(alu_control), 32'b101);
        tick();
        tick();
        applyStimulus(1'b0, ITY, 3'b110, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("ori_alu", 32'(alu_control), 32'b011);
        tick();
        tick();
        checkOutput("alu_mix_instret", 32'(instret), 32'd9);

        // jal
        applyStimulus(1'b0, JAL, 3'b000, 1'b0, 1'b0);
        tick();
        checkOutput("jal_imm", 32'(imm_src), 32'b11);
        tick();
        checkOutput("jal_state", 32'(sig), 32'(SIG_JAL));
        tick();
        checkOutput("jal_aluwb", 32'(sig), 32'(SIG_ALUWB));
        tick();
        checkOutput("jal_instret", 32'(instret), 32'd10);

        // illegal opcode
        applyStimulus(1'b0, BAD, 3'b000, 1'b0, 1'b0);
        tick();
        checkOutput("ill_decode", 32'(sig), 32'(SIG_DEC_ILL));
        tick();
        checkOutput("ill_fetch", 32'(sig), 32'(SIG_FETCH));
        checkOutput("ill_instret", 32'(instret), 32'd10);

        // counter wrap with 4-bit instret
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, BEQ, 3'b000, 1'b0, 1'b0);
            tick();
            tick();
            tick();
        end
        checkOutput("instret_15", 32'(instret), 32'd15);
        tick();
        tick();
        tick();
        checkOutput("instret_wrap", 32'(instret), 32'd0);
        tick();
        tick();
        tick();
        checkOutput("instret_after_wrap", 32'(instret), 32'd1);

        // reset asserted in MEMWB aborts the write
        applyStimulus(1'b0, LW, 3'b010, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        tick();
        checkOutput("abort_memwb", 32'(sig), 32'(SIG_MEMWB));
        applyStimulus(1'b1, LW, 3'b010, 1'b0, 1'b0);
        checkOutput("abort_reg_write", 32'(reg_write), 32'd0);
        checkOutput("abort_sig", 32'(sig), 32'(SIG_RST));
        tick();
        checkOutput("abort_instret", 32'(instret), 32'd0);
        applyStimulus(1'b0, LW, 3'b010, 1'b0, 1'b0);
        checkOutput("abort_fetch", 32'(sig), 32'(SIG_FETCH));

        $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
